// File: rtl/shifter_pipe_if.sv
// Operand-to-ALU shifter bus: input entry fields, flush, and the result handshake.
interface shifter_pipe_if #(
    parameter int unsigned FULLW  = 32,
    parameter int unsigned SHAMTW = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [FULLW-1:0]  rm_data;
    logic [FULLW-1:0]  bypass_rm;
    logic              should_bypass_rm;
    logic [1:0]        shiftcode;
    logic [SHAMTW-1:0] shiftby;
    logic              is_imm_shift;
    logic              rot_double;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [FULLW-1:0]  out_data;
    logic              out_carry;

    // Producer side: operand decode drives entries, ALU side drives out_ready.
    modport master (
        output flush, in_valid, rm_data, bypass_rm, should_bypass_rm, shiftcode,
               shiftby, is_imm_shift, rot_double, carry_in, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    // Shifter side.
    modport slave (
        input  flush, in_valid, rm_data, bypass_rm, should_bypass_rm, shiftcode,
               shiftby, is_imm_shift, rot_double, carry_in, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter producing the ALU second operand and shifter
// carry-out. Stage 1 selects the operand and normalises the shift amount, stage 2
// performs the shift and holds the result under a valid/ready handshake.
module shifter_pipe #(
    parameter int unsigned FULLW  = 32,
    parameter int unsigned SHAMTW = 8
) (
    input logic           clk,
    input logic           rst_n,
    shifter_pipe_if.slave bus
);
    localparam int unsigned IDXW = $clog2(FULLW);
    localparam logic [SHAMTW-1:0] N_FULL = SHAMTW'(FULLW);
    localparam logic [SHAMTW-1:0] N_ONE  = SHAMTW'(1);

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shcode_e;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic [FULLW-1:0]  s1_x_q,     s1_x_d;
    shcode_e           s1_code_q,  s1_code_d;
    logic [SHAMTW-1:0] s1_n_q,     s1_n_d;
    logic              s1_rrx_q,   s1_rrx_d;
    logic              s1_c_q,     s1_c_d;

    // Stage 2 registers
    logic              s2_valid_q, s2_valid_d;
    logic [FULLW-1:0]  s2_data_q,  s2_data_d;
    logic              s2_carry_q, s2_carry_d;

    // Handshake
    logic adv1, adv2, accept;

    // Stage 1 decode results
    logic [FULLW-1:0]  dec_x;
    logic [SHAMTW-1:0] dec_n_raw;
    logic [SHAMTW-1:0] dec_n;
    logic              dec_rrx;

    // Shift unit results
    logic [FULLW-1:0]  sh_data;
    logic              sh_carry;
    logic [IDXW-1:0]   sh_idx;
    logic [IDXW-1:0]   ror_m;
    logic [IDXW:0]     ror_inv;

    assign adv2   = !s2_valid_q || bus.out_ready;
    assign adv1   = !s1_valid_q || adv2;
    assign accept = bus.in_valid && adv1;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_carry = s2_carry_q;

    // Operand select, rotate-immediate doubling and #0 immediate encodings.
    always_comb begin
        dec_x     = bus.should_bypass_rm ? bus.bypass_rm : bus.rm_data;
        dec_n_raw = bus.rot_double ? {bus.shiftby[SHAMTW-2:0], 1'b0} : bus.shiftby;
        dec_n     = dec_n_raw;
        dec_rrx   = 1'b0;
        if (bus.is_imm_shift && (dec_n_raw == '0)) begin
            unique case (shcode_e'(bus.shiftcode))
                SH_LSR, SH_ASR: dec_n   = N_FULL;
                SH_ROR:         dec_rrx = 1'b1;
                default:        ;
            endcase
        end
    end

    // Stage 1 next state: flush kills, accept loads, otherwise empty when drained.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_code_d  = s1_code_q;
        s1_n_d     = s1_n_q;
        s1_rrx_d   = s1_rrx_q;
        s1_c_d     = s1_c_q;
        if (bus.flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_x_d     = dec_x;
            s1_code_d  = shcode_e'(bus.shiftcode);
            s1_n_d     = dec_n;
            s1_rrx_d   = dec_rrx;
            s1_c_d     = bus.carry_in;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    // Barrel shift of the stage 1 entry, including carry-out selection.
    always_comb begin
        sh_data  = s1_x_q;
        sh_carry = s1_c_q;
        sh_idx   = '0;
        ror_m    = s1_n_q[IDXW-1:0];
        ror_inv  = (IDXW+1)'(FULLW) - {1'b0, ror_m};
        if (s1_rrx_q) begin
            sh_data  = {s1_c_q, s1_x_q[FULLW-1:1]};
            sh_carry = s1_x_q[0];
        end else if (s1_n_q != '0) begin
            unique case (s1_code_q)
                SH_LSL: begin
                    if (s1_n_q < N_FULL) begin
                        sh_idx   = IDXW'(N_FULL - s1_n_q);
                        sh_data  = s1_x_q << s1_n_q;
                        sh_carry = s1_x_q[sh_idx];
                    end else if (s1_n_q == N_FULL) begin
                        sh_data  = '0;
                        sh_carry = s1_x_q[0];
                    end else begin
                        sh_data  = '0;
                        sh_carry = 1'b0;
                    end
                end
                SH_LSR: begin
                    if (s1_n_q < N_FULL) begin
                        sh_idx   = IDXW'(s1_n_q - N_ONE);
                        sh_data  = s1_x_q >> s1_n_q;
                        sh_carry = s1_x_q[sh_idx];
                    end else if (s1_n_q == N_FULL) begin
                        sh_data  = '0;
                        sh_carry = s1_x_q[FULLW-1];
                    end else begin
                        sh_data  = '0;
                        sh_carry = 1'b0;
                    end
                end
                SH_ASR: begin
                    if (s1_n_q < N_FULL) begin
                        sh_idx   = IDXW'(s1_n_q - N_ONE);
                        sh_data  = $signed(s1_x_q) >>> s1_n_q;
                        sh_carry = s1_x_q[sh_idx];
                    end else begin
                        sh_data  = {FULLW{s1_x_q[FULLW-1]}};
                        sh_carry = s1_x_q[FULLW-1];
                    end
                end
                SH_ROR: begin
                    // Only the low bits of the amount matter; a multiple of the
                    // width leaves the value intact but still reports bit 31.
                    if (ror_m == '0) begin
                        sh_data  = s1_x_q;
                        sh_carry = s1_x_q[FULLW-1];
                    end else begin
                        sh_idx   = ror_m - IDXW'(1);
                        sh_data  = (s1_x_q >> ror_m) | (s1_x_q << ror_inv);
                        sh_carry = s1_x_q[sh_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 2 next state: result data only changes when a live entry moves in,
    // so flush and bubbles leave the last result visible.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_carry_d = s2_carry_q;
        if (bus.flush) begin
            s2_valid_d = 1'b0;
        end else if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = sh_data;
                s2_carry_d = sh_carry;
            end
        end
    end

    // Stage 1 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_code_q  <= SH_LSL;
            s1_n_q     <= '0;
            s1_rrx_q   <= 1'b0;
            s1_c_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_code_q  <= s1_code_d;
            s1_n_q     <= s1_n_d;
            s1_rrx_q   <= s1_rrx_d;
            s1_c_q     <= s1_c_d;
        end
    end

    // Stage 2 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_carry_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_carry_q <= s2_carry_d;
        end
    end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Two-stage pipelined barrel shifter that consumes the decoded shifter-operand fields (rm value or bypass immediate, shift code, shift amount) and produces the ALU's second operand plus the shifter carry-out.
- Sits between register read / operand decode and the ALU.
- Uses a valid/ready handshake so a stall can be applied from the ALU side.
- Supports a flush input for branch redirects.

Parameters:
- FULLW, 32, operand/result width.
- SHAMTW, 8, shift-amount width; only values 0..255 are meaningful.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  input entry valid.
- in_ready  output  1  stage 1 can accept an entry this cycle.
- rm_data  input  FULLW  register-file read value of rm.
- bypass_rm  input  FULLW  immediate operand value.
- should_bypass_rm  input  1  1 selects bypass_rm, 0 selects rm_data.
- shiftcode  input  2  0=LSL, 1=LSR, 2=ASR, 3=ROR.
- shiftby  input  SHAMTW  raw shift amount.
- is_imm_shift  input  1  amount came from an instruction immediate field; enables the #0 special encodings.
- rot_double  input  1  effective amount = 2*shiftby (data-processing rotate immediate).
- carry_in  input  1  current CPSR C flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  FULLW  shifted operand.
- out_carry  output  1  shifter carry-out.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_carry=0. All stage registers are cleared.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational).
  - An entry is accepted when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_data and out_carry hold stable while out_valid & !out_ready.
- Latency: 2 cycles accept-to-out_valid when unstalled. Throughput is 1 per cycle.
- Stage 1 (register on accept):
  - x = should_bypass_rm ? bypass_rm : rm_data.
  - n = rot_double ? {shiftby[SHAMTW-2:0],1'b0} : shiftby.
  - Immediate normalization, applied when is_imm_shift & n==0:
    - LSR becomes n=32.
    - ASR becomes n=32.
    - ROR sets the rrx flag.
    - LSL is unchanged.
  - Register shiftcode, n, rrx and carry_in alongside x.
  - If s1 empties without new input, s1_valid clears.
- Stage 2 (register on adv2) computes {out_data, out_carry} from x, n, c=carry_in:
  - Any code with n==0 and no rrx: result x, carry c.
  - LSL:
    - n 1..31: x<<n, carry x[32-n].
    - n=32: 0, carry x[0].
    - n>32: 0, carry 0.
  - LSR:
    - n 1..31: x>>n, carry x[n-1].
    - n=32: 0, carry x[31].
    - n>32: 0, carry 0.
  - ASR:
    - n 1..31: arithmetic shift, carry x[n-1].
    - n>=32: all bits x[31], carry x[31].
  - ROR with n!=0:
    - m = n[4:0].
    - m==0: result x, carry x[31].
    - m!=0: rotate right by m, carry x[m-1].
  - rrx: result {c, x[31:1]}, carry x[0].
- Flush: on the next edge s1_valid=0 and s2_valid=0.
  - flush with a simultaneous accept drops the new entry; flush wins.
  - in_ready is still driven per the handshake rule during flush.
  - out_data and out_carry keep their last values; only the valid bits clear.
- Stall: when out_ready=0 with s2 full, s2 holds.
  - If s1 is also full, s1 holds and in_ready=0.
  - If s1 is empty, it may fill once.
- Reset asserted mid-operation drops every entry immediately; no partial output appears.

Test Plan:
- LSR imm #0: rm_data=0x80000001, is_imm_shift=1, LSR, shiftby=0, c=0 -> out_data=0, out_carry=1, out_valid exactly 2 cycles after accept.
- ROR imm #0 (RRX): x=0x00000003, c=1, ROR, shiftby=0, is_imm_shift=1 -> out_data=0x80000001, out_carry=1.
- Register amounts, x=0xF0000000, is_imm_shift=0:
  - ASR 40 -> 0xFFFFFFFF, carry 1.
  - LSL 32 -> 0, carry 0.
  - LSL 33 -> 0, carry 0.
  - ROR 32 -> 0xF0000000, carry 1.
  - shiftby=0 with c=1 -> x unchanged, carry 1.
- Rotate immediate: bypass_rm=0x000000FF, should_bypass_rm=1, ROR, shiftby=4, rot_double=1 -> out_data=0xFF000000, out_carry=1.
- Stall/backpressure: stream 4 back-to-back entries with out_ready=0 from cycle 2 -> in_ready drops after 2 accepted entries; on release all 4 results emerge in order, none duplicated.
- Flush and reset: flush the same cycle as an accept with s1 and s2 full -> out_valid=0 next cycle and the new entry never appears. Assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
